// File: rtl/seq_divider_10x5.sv
// -----------------------------------------------------------------------------
// seq_divider_10x5
//
// Sequential restoring divider, the arithmetic inverse of the 5x5 multiplier
// datapath. A 10-bit unsigned dividend is divided by a 5-bit unsigned divisor.
// One quotient bit is resolved per clock under a start/done handshake.
//
// Timing: an operation accepted in cycle c (start & ready) spends cycles
// c+1 .. c+DIVIDEND_W in RUN. done pulses in cycle c+DIVIDEND_W+1, and ready
// returns in the following cycle.
//
// Ports
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous, active-high reset
//   start        in   1           request, sampled only while ready=1
//   dividend     in   DIVIDEND_W  numerator, sampled with start
//   divisor      in   DIVISOR_W   denominator, sampled with start
//   ready        out  1           high in IDLE; start accepted on start&ready
//   busy         out  1           high in RUN
//   done         out  1           one-cycle pulse; results valid from here on
//   quotient     out  DIVIDEND_W  result, held until the next done
//   remainder    out  DIVISOR_W   result, held until the next done
//   div_by_zero  out  1           zero-divisor flag, valid with done
//
// Configuration
//   DIV_BY_ZERO_DETECT_EN  when defined, a zero divisor skips RUN and goes
//                          straight to DONE with quotient=all ones,
//                          remainder=0 and div_by_zero=1. When undefined,
//                          div_by_zero is tied low and a zero divisor runs
//                          the normal sequence (quotient=all ones,
//                          remainder=dividend[DIVISOR_W-1:0]).
// -----------------------------------------------------------------------------
module seq_divider_10x5 #(
    parameter int DIVIDEND_W = 10,
    parameter int DIVISOR_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    // One extra bit so the trial value {R, next dividend bit} never overflows.
    localparam int R_W   = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;             // dividend in, quotient out
    logic [DIVISOR_W-1:0]  den_q, den_d;         // latched divisor
    logic [R_W-1:0]        r_q, r_d;             // partial remainder
    logic [CNT_W-1:0]      cnt_q, cnt_d;         // iterations left
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

    // -------------------------------------------------------------------------
    // Single restoring step: bring down the next dividend bit and try to
    // subtract the divisor. The subtract is R_W bits wide, so it cannot wrap
    // when trial >= divisor.
    // -------------------------------------------------------------------------
    logic [R_W-1:0] trial;
    logic [R_W-1:0] diff;
    logic           fits;

    assign trial = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    assign fits  = (trial >= {1'b0, den_q});
    assign diff  = trial - {1'b0, den_q};

`ifdef DIV_BY_ZERO_DETECT_EN
    logic div_by_zero_q, div_by_zero_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        q_d         = q_q;
        den_d       = den_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_BY_ZERO_DETECT_EN
        div_by_zero_d = div_by_zero_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    den_d = divisor;
                    r_d   = '0;
                    cnt_d = CNT_W'(DIVIDEND_W);
`ifdef DIV_BY_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        // Short-circuit: the result is defined, no need to iterate.
                        state_d       = S_DONE;
                        quotient_d    = '1;
                        remainder_d   = '0;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end
            end

            S_RUN: begin
                r_d   = fits ? diff : trial;
                q_d   = {q_q[DIVIDEND_W-2:0], fits};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last bit resolved: publish results so they are valid
                    // during the DONE cycle and held afterwards.
                    state_d     = S_DONE;
                    quotient_d  = q_d;
                    remainder_d = r_d[DIVISOR_W-1:0];
`ifdef DIV_BY_ZERO_DETECT_EN
                    div_by_zero_d = 1'b0;
`endif
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // values from before this edge, regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            den_q       <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            den_q       <= den_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

`ifdef DIV_BY_ZERO_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            div_by_zero_q <= 1'b0;
        end else begin
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign div_by_zero = div_by_zero_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider_10x5.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_10x5
//
// Self-checking bench for seq_divider_10x5. Inputs are driven and outputs
// sampled on the falling clock edge. Expected results come from plain
// integer division in the bench, with the zero-divisor behaviour selected by
// DIV_BY_ZERO_DETECT_EN to match the build under test.
// -----------------------------------------------------------------------------
module tb_seq_divider_10x5;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] dividend;
    logic [4:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider_10x5 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: what the divider must return for a/b and how many cycles
    // from accept to done.
    function automatic void model(input int a, input int b,
                                  output int q, output int r,
                                  output int dz, output int lat);
        if (b == 0) begin
            q = 1023;
`ifdef DIV_BY_ZERO_DETECT_EN
            r   = 0;
            dz  = 1;
            lat = 1;
`else
            r   = a % 32;
            dz  = 0;
            lat = 11;
`endif
        end else begin
            q   = a / b;
            r   = a % b;
            dz  = 0;
            lat = 11;
        end
    endfunction

    // Issues one operation from a falling edge with ready high, scrambles the
    // inputs after acceptance, waits (bounded) for done and checks everything.
    task automatic run_op(input int a, input int b, input string tag);
        int eq, er, edz, elat;
        int lat, busy_n;
        model(a, b, eq, er, edz, elat);
        chk({tag, "_ready"}, ready, 1);
        start    = 1'b1;
        dividend = 10'(a);
        divisor  = 5'(b);
        lat      = 0;
        busy_n   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start    = 1'b0;
                dividend = 10'($urandom);
                divisor  = 5'($urandom);
            end
            if (busy) busy_n++;
        end while (!done && lat < 30);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_busy_cycles"}, busy_n, elat - 1);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        if (b != 0) begin
            chk({tag, "_identity"}, quotient * b + remainder, a);
            chk({tag, "_rem_lt_div"}, remainder < b, 1);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_after"}, ready, 1);
    endtask

    initial begin
        int lat, seen, a, b;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic directed case.
        run_op(1000, 7, "d1000_7");

        // Back-to-back with start held high throughout.
        start    = 1'b1;
        dividend = 10'd1023;
        divisor  = 5'd31;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 30);
        chk("b2b1_latency", lat, 11);
        chk("b2b1_quotient", quotient, 33);
        chk("b2b1_remainder", remainder, 0);
        dividend = 10'd5;
        divisor  = 5'd9;
        @(negedge clk);
        chk("b2b2_ready", ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("b2b2_busy", busy, 1);
                start = 1'b0;
            end
        end while (!done && lat < 30);
        chk("b2b2_latency", lat, 11);
        chk("b2b2_quotient", quotient, 0);
        chk("b2b2_remainder", remainder, 5);
        @(negedge clk);

        // A second request during RUN must be ignored.
        start    = 1'b1;
        dividend = 10'd1000;
        divisor  = 5'd25;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                dividend = 10'd300;
                divisor  = 5'd3;
            end
            if (lat == 5) chk("ign_ready_low", ready, 0);
            if (lat == 8) start = 1'b0;
        end while (!done && lat < 30);
        chk("ign_latency", lat, 11);
        chk("ign_quotient", quotient, 40);
        chk("ign_remainder", remainder, 0);
        @(negedge clk);
        chk("ign_ready_after", ready, 1);
        @(negedge clk);
        chk("ign_not_reaccepted", busy, 0);

        // Zero divisor.
        run_op(500, 0, "d500_0");

        // Reset in the middle of a run.
        run_op(1000, 7, "pre_rst");
        start    = 1'b1;
        dividend = 10'd1000;
        divisor  = 5'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quotient", quotient, 0);
        chk("mid_rst_remainder", remainder, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mid_rst_no_done", seen, 0);
        run_op(1000, 7, "post_rst");

        // Boundary pairs.
        run_op(0, 1, "d0_1");
        run_op(1023, 1, "d1023_1");
        run_op(30, 31, "d30_31");
        run_op(31, 31, "d31_31");
        run_op(1023, 0, "d1023_0");

        // Random sweep over nonzero divisors.
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 1023));
            b = int'($urandom_range(1, 31));
            run_op(a, b, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
